// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU: opcodes, controller states
// and the bit positions of the {V,C,N,Z} flag vector.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int FLAG_V = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  function automatic logic [3:0] pack_flags(input logic v, input logic c,
                                            input logic n, input logic z);
    logic [3:0] f;
    f         = '0;
    f[FLAG_V] = v;
    f[FLAG_C] = c;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    return f;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned N x N shift-add multiplier, one iteration per clock. done and product
// are combinational: they describe the final iteration that completes on the coming edge.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter  int N  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam logic [SW:0] ITERS   = (SW+1)'(N);
  localparam logic [SW:0] CNT_ONE = (SW+1)'(1);

  logic [2*N-1:0] prod_q, prod_d;
  logic [N-1:0]   mcand_q, mcand_d;
  logic [SW:0]    cnt_q, cnt_d;
  logic [N:0]     partial;

  // Upper half accumulates the multiplicand; lower half shifts the multiplier out.
  always_comb begin
    prod_d  = prod_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    partial = {1'b0, prod_q[2*N-1:N]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    if (start && !busy) begin
      prod_d  = {{N{1'b0}}, b};
      mcand_d = a;
      cnt_d   = ITERS;
    end else if (busy) begin
      prod_d  = {partial, prod_q[N-1:1]};
      cnt_d   = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q  <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
    end else begin
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy    = (cnt_q != '0);
  assign done    = (cnt_q == CNT_ONE);
  assign product = prod_d;

endmodule

// File: rtl/alu_seq.sv
// Registered, handshaked ALU: single-cycle logic/arith/shift ops and a multi-cycle
// unsigned multiply, with registered {V,C,N,Z} flags held until the consumer accepts.
module alu_seq
  import alu_pkg::*;
#(
  parameter  int N  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  op_e          op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] y,
  output logic [N-1:0] y_hi,
  output logic [3:0]   flags
);

  state_e         state_q, state_d;
  logic [N-1:0]   y_q, y_d, y_hi_q, y_hi_d;
  logic [3:0]     flags_q, flags_d;
  logic           accept, mul_start, mul_busy, mul_done;
  logic [2*N-1:0] mul_product;
  logic [SW-1:0]  shamt;
  logic [N:0]     sum, diff, shl_w, shr_w;
  logic [N-1:0]   alu_y;
  logic           alu_v, alu_c;

  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op == OP_MUL);

  alu_mul_seq #(.N(N)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Shifts run one bit wider so the last bit shifted out lands in the extra position.
  always_comb begin
    shamt = b[SW-1:0];
    sum   = {1'b0, a} + {1'b0, b};
    diff  = {1'b0, a} - {1'b0, b};
    shl_w = {1'b0, a} << shamt;
    shr_w = {a, 1'b0} >> shamt;
    alu_y = '0;
    alu_v = 1'b0;
    alu_c = 1'b0;
    case (op)
      OP_ADD: begin
        alu_y = sum[N-1:0];
        alu_c = sum[N];
        alu_v = (a[N-1] == b[N-1]) && (alu_y[N-1] != a[N-1]);
      end
      OP_SUB: begin
        alu_y = diff[N-1:0];
        alu_c = ~diff[N];
        alu_v = (a[N-1] != b[N-1]) && (alu_y[N-1] != a[N-1]);
      end
      OP_AND: alu_y = a & b;
      OP_OR:  alu_y = a | b;
      OP_XOR: alu_y = a ^ b;
      OP_SHL: begin
        alu_y = shl_w[N-1:0];
        alu_c = shl_w[N];
      end
      OP_SHR: begin
        alu_y = shr_w[N:1];
        alu_c = shr_w[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    y_d     = y_q;
    y_hi_d  = y_hi_q;
    flags_d = flags_q;
    if (accept && (op != OP_MUL)) begin
      y_d     = alu_y;
      y_hi_d  = '0;
      flags_d = pack_flags(alu_v, alu_c, alu_y[N-1], alu_y == '0);
    end else if ((state_q == EXEC) && mul_done) begin
      y_d     = mul_product[N-1:0];
      y_hi_d  = mul_product[2*N-1:N];
      flags_d = pack_flags(1'b0, |mul_product[2*N-1:N], mul_product[2*N-1],
                           mul_product == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q     <= '0;
      y_hi_q  <= '0;
      flags_q <= '0;
    end else begin
      y_q     <= y_d;
      y_hi_q  <= y_hi_d;
      flags_q <= flags_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = (op == OP_MUL) ? EXEC : DONE;
      EXEC: if (mul_done) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The multiplier is never busy in IDLE; gating on it keeps a stray start impossible.
  always_comb begin
    in_ready  = (state_q == IDLE) && !mul_busy;
    out_valid = (state_q == DONE);
    y         = y_q;
    y_hi      = y_hi_q;
    flags     = flags_q;
  end

endmodule
